// File: rtl/riscv_commit_trace.sv
// Commit trace capture: packs per-cycle register write-back and data-memory side effects
// into timestamped records and queues them in a FIFO drained over a valid/ready port.
module riscv_commit_trace #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic                     clear,
  input  logic                     reg_write_sig,
  input  logic [4:0]               reg_num,
  input  logic [31:0]              reg_data,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [8:0]               addr,
  input  logic [31:0]              wr_data,
  input  logic [31:0]              rd_data,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [TS_W+80:0]         trace_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned REC_W = TS_W + 81;

  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [AW:0]       wptr_q, rptr_q;
  logic [TS_W-1:0]   ts_q;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_q;

  logic              has_reg, has_mem, rec_valid;
  logic [REC_W-1:0]  rec;
  logic              full, pop, push, drop;

  always_comb begin
    has_reg   = reg_write_sig && (reg_num != 5'd0);
    has_mem   = wr || rd;
    rec_valid = trace_en && (has_reg || has_mem);
    // Absent events contribute all-zero fields; a simultaneous write wins over a read.
    rec = {ts_q, has_reg, has_mem, wr,
           has_reg ? reg_num : 5'd0,
           has_mem ? addr : 9'd0,
           has_reg ? reg_data : 32'd0,
           wr ? wr_data : (rd ? rd_data : 32'd0)};
  end

  assign level       = wptr_q - rptr_q;
  assign full        = (level == (AW + 1)'(DEPTH));
  assign trace_valid = (level != '0);
  assign pop         = trace_valid && trace_ready;
  assign push        = rec_valid && (!full || pop);
  assign drop        = rec_valid && full && !pop;
  assign trace_data  = trace_valid ? mem_q[rptr_q[AW-1:0]] : '0;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= rec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (push) wptr_q <= wptr_q + (AW + 1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW + 1)'(1);
      // Clear dominates, so a drop coinciding with clear is not counted.
      if (clear) begin
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_commit_trace.sv
// Directed self-checking bench for riscv_commit_trace with hand-computed trace records.
module tb_riscv_commit_trace;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en, clear;
  logic        reg_write_sig;
  logic [4:0]  reg_num;
  logic [31:0] reg_data;
  logic        wr, rd;
  logic [8:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        trace_valid, trace_ready;
  logic [96:0] trace_data;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] ts_now = 16'd0;
  logic [96:0] q [$];
  logic [96:0] exp_rec;

  riscv_commit_trace dut (
    .clk           (clk),
    .reset         (reset),
    .trace_en      (trace_en),
    .clear         (clear),
    .reg_write_sig (reg_write_sig),
    .reg_num       (reg_num),
    .reg_data      (reg_data),
    .wr            (wr),
    .rd            (rd),
    .addr          (addr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_data    (trace_data),
    .level         (level),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [96:0] mk(input logic [15:0] ts, input logic hr, input logic hm,
                                     input logic mw, input logic [4:0] rn, input logic [8:0] a,
                                     input logic [31:0] rv, input logic [31:0] mv);
    return {ts, hr, hm, mw, rn, a, rv, mv};
  endfunction

  // ts_now mirrors the DUT counter value after each edge.
  task automatic step();
    @(posedge clk);
    if (reset) ts_now++;
    #1;
  endtask

  task automatic idle();
    reg_write_sig = 0; reg_num = 0; reg_data = 0;
    wr = 0; rd = 0; addr = 0; wr_data = 0; rd_data = 0;
  endtask

  task automatic ev(input logic rw, input logic [4:0] rn, input logic [31:0] rv, input logic w,
                    input logic r, input logic [8:0] a, input logic [31:0] wd,
                    input logic [31:0] rdd);
    reg_write_sig = rw; reg_num = rn; reg_data = rv;
    wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd;
  endtask

  initial begin
    reset = 0; trace_en = 1; clear = 0; trace_ready = 0;
    idle();
    step(); step();
    check("rst_valid", trace_valid, 0);
    check("rst_level", level, 0);
    check("rst_data", trace_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_count, 0);

    reset = 1; ts_now = 0;
    step(); step(); step();
    // 1: single register write at ts=3
    trace_ready = 1;
    ev(1, 5'd5, 32'h2A, 0, 0, 0, 0, 0);
    exp_rec = mk(ts_now, 1, 0, 0, 5'd5, 0, 32'h2A, 0);
    check("t1_ts3", ts_now, 3);
    step(); idle();
    check("t1_valid", trace_valid, 1);
    check("t1_rec", trace_data, exp_rec);
    step();
    check("t1_empty", trace_valid, 0);

    // 2: register write and memory write in one record
    trace_ready = 0;
    ev(1, 5'd1, 32'd7, 1, 0, 9'd16, 32'hDEADBEEF, 0);
    exp_rec = mk(ts_now, 1, 1, 1, 5'd1, 9'd16, 32'd7, 32'hDEADBEEF);
    step(); idle();
    check("t2_rec", trace_data, exp_rec);
    check("t2_level", level, 1);
    trace_ready = 1; step(); trace_ready = 0;

    // 3: write wins over read; x0 ignored; read-only; trace_en gating
    ev(0, 0, 0, 1, 1, 9'd4, 32'd1, 32'd2);
    exp_rec = mk(ts_now, 0, 1, 1, 0, 9'd4, 0, 32'd1);
    step(); idle();
    check("t3_wrrd", trace_data, exp_rec);
    trace_ready = 1;
    ev(1, 5'd0, 32'h99, 0, 0, 0, 0, 0);
    step(); idle(); trace_ready = 0;
    check("t3_x0_level", level, 0);
    ev(1, 5'd0, 32'h99, 0, 1, 9'd9, 32'h77, 32'h55);
    exp_rec = mk(ts_now, 0, 1, 0, 0, 9'd9, 0, 32'h55);
    step(); idle();
    check("t3_rdonly", trace_data, exp_rec);
    trace_ready = 1; step(); trace_ready = 0;
    trace_en = 0;
    ev(1, 5'd3, 32'h1, 1, 0, 9'd1, 32'h2, 0);
    step(); idle(); trace_en = 1;
    check("t3_en_off", level, 0);

    // 4: overfill with ready low
    for (int i = 0; i < 18; i++) begin
      ev(1, 5'(i % 31 + 1), 32'h100 + i, 0, 0, 0, 0, 0);
      if (i < 16) q.push_back(mk(ts_now, 1, 0, 0, 5'(i % 31 + 1), 0, 32'h100 + i, 0));
      step();
    end
    idle();
    check("t4_level", level, 16);
    check("t4_ovf", overflow, 1);
    check("t4_drop", drop_count, 2);
    check("t4_head", trace_data, q[0]);
    step();
    check("t4_hold", trace_data, q[0]);

    // 5: full with simultaneous pop and push, then clear behaviour
    trace_ready = 1;
    ev(1, 5'd3, 32'hABC, 0, 0, 0, 0, 0);
    void'(q.pop_front());
    q.push_back(mk(ts_now, 1, 0, 0, 5'd3, 0, 32'hABC, 0));
    step(); idle(); trace_ready = 0;
    check("t5_level", level, 16);
    check("t5_drop", drop_count, 2);
    clear = 1; step(); clear = 0;
    check("t5_clr_ovf", overflow, 0);
    check("t5_clr_drop", drop_count, 0);
    clear = 1; ev(1, 5'd4, 32'h4, 0, 0, 0, 0, 0);
    step(); idle(); clear = 0;
    check("t5_clrdrop_cnt", drop_count, 0);
    check("t5_clrdrop_ovf", overflow, 0);
    ev(1, 5'd4, 32'h4, 0, 0, 0, 0, 0);
    step(); idle();
    check("t5_drop1", drop_count, 1);
    check("t5_ovf1", overflow, 1);
    clear = 1; step(); clear = 0;

    trace_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check("t4_drain_valid", trace_valid, 1);
      exp_rec = q.pop_front();
      check("t4_drain_rec", trace_data, exp_rec);
      step();
    end
    check("t4_done_valid", trace_valid, 0);
    check("t4_done_level", level, 0);
    trace_ready = 0;

    // 6: asynchronous reset mid-drain
    for (int i = 0; i < 5; i++) begin
      ev(0, 0, 0, 1, 0, 9'(i), 32'(i), 0);
      step();
    end
    idle();
    check("t6_level5", level, 5);
    trace_ready = 1;
    #1 reset = 0;
    #1;
    check("t6_async_valid", trace_valid, 0);
    check("t6_async_level", level, 0);
    trace_ready = 0;
    step(); step();
    reset = 1; ts_now = 0;
    ev(1, 5'd9, 32'h9, 0, 0, 0, 0, 0);
    step(); idle();
    check("t6_ts0", trace_data, mk(16'd0, 1, 0, 0, 5'd9, 0, 32'h9, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
